// File: rtl/yuv420_unpack.sv
// Unpacks a 32-bit packed byte stream into Y/U/V pixels (raw, full YUV or 4:2:0),
// regenerating row framing from the latched frame geometry.
module yuv420_unpack #(
  parameter int unsigned MAX_COLS = 1288,
  parameter int unsigned DTYPE_WIDTH = 4,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 'd1,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 'd2,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 'd3,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 'd4,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 'd5,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 'd6,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 'd7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            image_type,
  input  logic                   enable,
  input  logic [15:0]            num_cols,
  input  logic [15:0]            num_rows,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]            datai,
  output logic                   rdyo,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [7:0]             yo,
  output logic [7:0]             uo,
  output logic [7:0]             vo,
  output logic                   uv_valid,
  output logic [15:0]            meta_datao
);

  localparam int unsigned ColW = (MAX_COLS > 2) ? $clog2(MAX_COLS) : 1;

  typedef enum logic [2:0] {StIdle, StHdr, StRows, StPix, StRowe, StFend} state_e;

  state_e          state_q;
  logic [63:0]     fifo_q;
  logic [3:0]      cnt_q;
  logic [ColW-1:0] col_q;
  logic [15:0]     row_q;
  logic            raw_q, sub_q, framed_q, hdr2_q, abort_q;
  logic [15:0]     ncols_q, nrows_q, hdr_hi_q;

  logic        accept, append, emit_pix, last_col, more_rows;
  logic [3:0]  need, consumed, cnt_left, cnt_next;
  logic [63:0] fifo_left, fifo_next;

  always_comb begin
    if (raw_q)                                   need = 4'd1;
    else if (!sub_q || (row_q[0] && col_q[0]))   need = 4'd3;
    else                                         need = 4'd1;
  end

  assign accept    = dvi && rdyo;
  assign append    = accept && (dtypei == DTYPE_PIXEL) &&
                     ((state_q == StIdle && framed_q) ||
                      (state_q inside {StHdr, StRows, StPix, StRowe}));
  assign emit_pix  = (state_q == StPix) && (cnt_q >= need);
  assign consumed  = emit_pix ? need : 4'd0;
  assign cnt_left  = cnt_q - consumed;
  assign fifo_left = fifo_q >> {consumed, 3'b000};
  assign fifo_next = append ? (fifo_left | ({32'd0, datai} << {cnt_left, 3'b000})) : fifo_left;
  assign cnt_next  = append ? cnt_left + 4'd4 : cnt_left;
  assign last_col  = (16'(col_q) == ncols_q - 16'd1);
  assign more_rows = ({1'b0, row_q} + 17'd1) < {1'b0, nrows_q};

  // Backpressure wherever bytes can be buffered, so a beat never overflows the 8-byte FIFO.
  always_comb begin
    rdyo = 1'b1;
    if (hdr2_q || abort_q)                          rdyo = 1'b0;
    else if (state_q inside {StRows, StPix, StRowe}) rdyo = (cnt_q <= 4'd4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fifo_q     <= '0;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      raw_q      <= 1'b0;
      sub_q      <= 1'b0;
      framed_q   <= 1'b0;
      hdr2_q     <= 1'b0;
      abort_q    <= 1'b0;
      ncols_q    <= '0;
      nrows_q    <= '0;
      hdr_hi_q   <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
      uv_valid   <= 1'b0;
      meta_datao <= '0;
    end else begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
      uv_valid   <= 1'b0;
      meta_datao <= '0;
      fifo_q     <= fifo_next;
      cnt_q      <= cnt_next;
      if (accept && dtypei == DTYPE_FRAME_START) begin
        dvo      <= 1'b1;
        dtypeo   <= DTYPE_FRAME_START;
        fifo_q   <= '0;
        cnt_q    <= '0;
        col_q    <= '0;
        row_q    <= '0;
        raw_q    <= (image_type == 16'd0);
        sub_q    <= enable;
        ncols_q  <= num_cols;
        nrows_q  <= num_rows;
        framed_q <= 1'b1;
        hdr2_q   <= 1'b0;
        abort_q  <= 1'b0;
        state_q  <= StIdle;
      end else if (accept && dtypei == DTYPE_FRAME_END &&
                   state_q inside {StHdr, StRows, StPix, StRowe}) begin
        // Early frame end: close an open row first, FRAME_END follows from StFend.
        fifo_q <= '0;
        cnt_q  <= '0;
        dvo    <= 1'b1;
        if (state_q inside {StPix, StRowe}) begin
          dtypeo  <= DTYPE_ROW_END;
          abort_q <= 1'b1;
          state_q <= StFend;
        end else begin
          dtypeo   <= DTYPE_FRAME_END;
          framed_q <= 1'b0;
          state_q  <= StIdle;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept && dtypei == DTYPE_HEADER_START && framed_q) begin
              dvo     <= 1'b1;
              dtypeo  <= DTYPE_HEADER_START;
              state_q <= StHdr;
            end else if (append) begin
              state_q <= StRows;
            end
          end
          StHdr: begin
            if (hdr2_q) begin
              dvo        <= 1'b1;
              dtypeo     <= DTYPE_HEADER;
              meta_datao <= hdr_hi_q;
              hdr2_q     <= 1'b0;
            end else if (accept) begin
              if (dtypei == DTYPE_HEADER) begin
                dvo        <= 1'b1;
                dtypeo     <= DTYPE_HEADER;
                meta_datao <= datai[15:0];
                hdr_hi_q   <= datai[31:16];
                hdr2_q     <= 1'b1;
              end else begin
                state_q <= StRows;
              end
            end
          end
          StRows: begin
            dvo     <= 1'b1;
            dtypeo  <= DTYPE_ROW_START;
            state_q <= StPix;
          end
          StPix: begin
            if (emit_pix) begin
              dvo    <= 1'b1;
              dtypeo <= DTYPE_PIXEL;
              yo     <= fifo_q[7:0];
              if (!raw_q && need == 4'd3) begin
                uo       <= fifo_q[15:8];
                vo       <= fifo_q[23:16];
                uv_valid <= 1'b1;
              end else begin
                uo <= 8'h80;
                vo <= 8'h80;
              end
              meta_datao <= raw_q ? {8'h00, fifo_q[7:0]} : 16'h0000;
              if (last_col) begin
                col_q   <= '0;
                state_q <= StRowe;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          StRowe: begin
            dvo    <= 1'b1;
            dtypeo <= DTYPE_ROW_END;
            if (more_rows) begin
              row_q   <= row_q + 16'd1;
              state_q <= StRows;
            end else begin
              fifo_q  <= '0;
              cnt_q   <= '0;
              state_q <= StFend;
            end
          end
          StFend: begin
            fifo_q <= '0;
            cnt_q  <= '0;
            if (abort_q || (accept && dtypei == DTYPE_FRAME_END)) begin
              dvo      <= 1'b1;
              dtypeo   <= DTYPE_FRAME_END;
              abort_q  <= 1'b0;
              framed_q <= 1'b0;
              state_q  <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yuv420_unpack.sv
// Self-checking bench for yuv420_unpack: directed frames plus random frames checked
// against an event-list model built from the frame geometry and byte stream.
module tb_yuv420_unpack;

  localparam logic [3:0] DT_FS = 4'd1, DT_FE = 4'd2, DT_HS = 4'd3, DT_HDR = 4'd4;
  localparam logic [3:0] DT_RS = 4'd5, DT_RE = 4'd6, DT_PIX = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] image_type, num_cols, num_rows;
  logic        enable, dvi;
  logic [3:0]  dtypei;
  logic [31:0] datai;
  logic        rdyo, dvo, uv_valid;
  logic [3:0]  dtypeo;
  logic [7:0]  yo, uo, vo;
  logic [15:0] meta_datao;

  typedef struct packed {
    logic [3:0]  dt;
    logic [7:0]  y;
    logic [7:0]  u;
    logic [7:0]  v;
    logic        uv;
    logic [15:0] meta;
  } ev_t;

  ev_t        obs[$];
  ev_t        exp_q[$];
  logic [7:0] stim[$];
  logic       rdy_after[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         gaps = 1'b1;

  always #5 clk = ~clk;

  yuv420_unpack dut (
    .clk        (clk),
    .reset      (reset),
    .image_type (image_type),
    .enable     (enable),
    .num_cols   (num_cols),
    .num_rows   (num_rows),
    .dvi        (dvi),
    .dtypei     (dtypei),
    .datai      (datai),
    .rdyo       (rdyo),
    .dvo        (dvo),
    .dtypeo     (dtypeo),
    .yo         (yo),
    .uo         (uo),
    .vo         (vo),
    .uv_valid   (uv_valid),
    .meta_datao (meta_datao)
  );

  always @(negedge clk) begin
    if (!reset && dvo) obs.push_back(ev_t'{dtypeo, yo, uo, vo, uv_valid, meta_datao});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic ev_t mk(input logic [3:0] dt, input logic [7:0] y, input logic [7:0] u,
                             input logic [7:0] v, input logic uv, input logic [15:0] meta);
    return ev_t'{dt, y, u, v, uv, meta};
  endfunction

  function automatic int pix_bytes(input bit raw, input bit en, input int r, input int c);
    if (raw) return 1;
    if (!en || ((r % 2 == 1) && (c % 2 == 1))) return 3;
    return 1;
  endfunction

  function automatic int frame_bytes(input bit raw, input bit en, input int cols, input int rows);
    int n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) n += pix_bytes(raw, en, r, c);
    return n;
  endfunction

  function automatic int count_pix();
    int n = 0;
    foreach (obs[i]) if (obs[i].dt == DT_PIX) n++;
    return n;
  endfunction

  // Beat is held until accepted; returns at the negedge after the transfer edge.
  task automatic send(input logic [3:0] dt, input logic [31:0] d);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    dvi = 1'b1;
    dtypei = dt;
    datai = d;
    while (rdyo !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", rdyo, 1);
    @(negedge clk);
    dvi = 1'b0;
    dtypei = 4'd0;
    datai = $urandom;
  endtask

  task automatic run_frame(input bit raw, input bit en, input int cols, input int rows,
                           input int nhdr, input int cut, input bit first_hdr, input bit skip_fe);
    logic [31:0] hw[$];
    int total, nw, idx, need;
    bit aborted;
    while (stim.size() % 4 != 0) stim.push_back(8'($urandom_range(0, 255)));
    total = stim.size() / 4;
    nw = (cut > 0 && cut < total) ? cut : total;
    for (int i = 0; i < nhdr; i++) hw.push_back((i == 0 && first_hdr) ? 32'hBEEF1234 : $urandom);

    exp_q.delete();
    exp_q.push_back(mk(DT_FS, 0, 0, 0, 0, 0));
    if (nhdr > 0) begin
      exp_q.push_back(mk(DT_HS, 0, 0, 0, 0, 0));
      foreach (hw[i]) begin
        exp_q.push_back(mk(DT_HDR, 0, 0, 0, 0, hw[i][15:0]));
        exp_q.push_back(mk(DT_HDR, 0, 0, 0, 0, hw[i][31:16]));
      end
    end
    idx = 0;
    aborted = 1'b0;
    for (int r = 0; r < rows && !aborted; r++) begin
      exp_q.push_back(mk(DT_RS, 0, 0, 0, 0, 0));
      for (int c = 0; c < cols; c++) begin
        need = pix_bytes(raw, en, r, c);
        if (idx + need > nw * 4) begin
          aborted = 1'b1;
          break;
        end
        if (raw)            exp_q.push_back(mk(DT_PIX, stim[idx], 8'h80, 8'h80, 0, {8'h00, stim[idx]}));
        else if (need == 3) exp_q.push_back(mk(DT_PIX, stim[idx], stim[idx+1], stim[idx+2], 1, 0));
        else                exp_q.push_back(mk(DT_PIX, stim[idx], 8'h80, 8'h80, 0, 0));
        idx += need;
      end
      if (!(aborted && skip_fe)) exp_q.push_back(mk(DT_RE, 0, 0, 0, 0, 0));
    end
    if (!skip_fe) exp_q.push_back(mk(DT_FE, 0, 0, 0, 0, 0));

    obs.delete();
    image_type = raw ? 16'd0 : 16'($urandom_range(1, 65535));
    enable = en;
    num_cols = 16'(cols);
    num_rows = 16'(rows);
    send(DT_FS, $urandom);
    image_type = 16'($urandom);
    enable = 1'($urandom);
    num_cols = 16'($urandom);
    num_rows = 16'($urandom);
    if (nhdr > 0) begin
      send(DT_HS, $urandom);
      foreach (hw[i]) begin
        send(DT_HDR, hw[i]);
        check("hdr_rdyo_low", rdyo, 0);
      end
    end
    send(DT_RS, $urandom);
    rdy_after.delete();
    for (int w = 0; w < nw; w++) begin
      send(DT_PIX, {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
      rdy_after.push_back(rdyo);
    end
    repeat (40) @(negedge clk);
    if (!skip_fe) send(DT_FE, $urandom);
    repeat (4) @(negedge clk);

    check("event_count", obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("event%0d", i), obs[i], exp_q[i]);
    stim.delete();
  endtask

  initial begin
    int cols, rows, nb, n;
    bit raw, en, trunc;
    reset = 1'b1;
    dvi = 1'b0;
    dtypei = '0;
    datai = '0;
    image_type = '0;
    enable = 1'b0;
    num_cols = '0;
    num_rows = '0;
    repeat (3) @(negedge clk);
    check("rst_dvo", dvo, 0);
    check("rst_dtypeo", dtypeo, 0);
    check("rst_yuv", {yo, uo, vo, uv_valid}, 0);
    check("rst_meta", meta_datao, 0);
    check("rst_rdyo", rdyo, 1);
    reset = 1'b0;
    @(negedge clk);

    // Raw 4x2, bytes 0..7
    for (int i = 0; i < 8; i++) stim.push_back(8'(i));
    run_frame(1, 0, 4, 2, 0, 0, 0, 0);

    // 4:2:0 2x2: only pixel (1,1) carries chroma
    stim = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h50};
    run_frame(0, 1, 2, 2, 0, 0, 0, 0);

    // Full YUV 4x1, back-to-back beats must see backpressure
    gaps = 1'b0;
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom_range(0, 255)));
    run_frame(0, 0, 4, 1, 0, 0, 0, 0);
    check("rdyo_drop", rdy_after[1], 0);
    gaps = 1'b1;

    // Header split into halves
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom_range(0, 255)));
    run_frame(1, 0, 2, 2, 1, 0, 1, 0);

    // Early frame end inside the second row
    for (int i = 0; i < 8; i++) stim.push_back(8'(8'h10 + i));
    run_frame(1, 0, 4, 2, 0, 1, 0, 0);

    // Reset after 3 of 8 pixels
    obs.delete();
    image_type = 16'd0;
    num_cols = 16'd8;
    num_rows = 16'd1;
    send(DT_FS, 0);
    send(DT_PIX, 32'h03020100);
    send(DT_PIX, 32'h07060504);
    n = 0;
    while (count_pix() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pix_before_reset", count_pix() >= 3, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dvo", {dvo, dtypeo}, 0);
    check("midrst_yuv", {yo, uo, vo, uv_valid, meta_datao}, 0);
    check("midrst_rdyo", rdyo, 1);
    reset = 1'b0;
    obs.delete();
    send(DT_PIX, 32'hDEADBEEF);
    repeat (10) @(negedge clk);
    check("no_out_without_fs", obs.size(), 0);
    for (int i = 0; i < 8; i++) stim.push_back(8'(i));
    run_frame(1, 0, 8, 1, 0, 0, 0, 0);

    // Random frames, some truncated and some abandoned by a fresh FRAME_START
    for (int f = 0; f < 12; f++) begin
      raw = ($urandom_range(0, 2) == 0);
      en = 1'($urandom);
      cols = $urandom_range(1, 6);
      rows = $urandom_range(1, 4);
      nb = frame_bytes(raw, en, cols, rows);
      for (int i = 0; i < nb; i++) stim.push_back(8'($urandom_range(0, 255)));
      trunc = ($urandom_range(0, 3) == 0);
      run_frame(raw, en, cols, rows, $urandom_range(0, 2), trunc ? $urandom_range(1, 6) : 0,
                0, trunc && $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
